// File: rtl/micro_computer.sv
// SAP-style 8-bit accumulator microcomputer with a 16x8 unified RAM, a host load port and an output port.
// Optional ALU extension (AND/OR/XOR/SHL/SHR on opcodes 9-D) is enabled by defining MC_EXT_ALU_EN.
module micro_computer #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              prog_we,
  input  logic [MEM_AW-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [MEM_AW-1:0] pc,
  output logic [DATA_W-1:0] acc
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                         OP_AND = 4'h9, OP_OR  = 4'hA, OP_XOR = 4'hB, OP_SHL = 4'hC,
                         OP_SHR = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF;

  logic [DATA_W-1:0] mem [2**MEM_AW];
  state_t            state, state_nx;
  logic [DATA_W-1:0] ir, ir_nx, acc_nx, out_nx;
  logic [MEM_AW-1:0] pc_nx;
  logic              c_flag, z_flag, c_nx, z_nx, out_valid_nx, halted_nx, cpu_we;

  logic [3:0]        opcode;
  logic [MEM_AW-1:0] opnd;
  logic [DATA_W-1:0] opnd_data;

  assign opcode    = ir[DATA_W-1 -: 4];
  assign opnd      = ir[MEM_AW-1:0];
  assign opnd_data = mem[opnd];

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    acc_nx       = acc;
    ir_nx        = ir;
    c_nx         = c_flag;
    z_nx         = z_flag;
    out_nx       = out_data;
    out_valid_nx = 1'b0;
    halted_nx    = halted;
    cpu_we       = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (run) begin
          ir_nx    = mem[pc];
          pc_nx    = pc + MEM_AW'(1);
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (opcode)
          OP_LDA: acc_nx = opnd_data;
          OP_ADD: begin
            {c_nx, acc_nx} = {1'b0, acc} + {1'b0, opnd_data};
            z_nx = (acc_nx == '0);
          end
          // The ninth bit of the widened difference is the borrow.
          OP_SUB: begin
            {c_nx, acc_nx} = {1'b0, acc} - {1'b0, opnd_data};
            z_nx = (acc_nx == '0);
          end
          OP_STA: cpu_we = 1'b1;
          OP_LDI: acc_nx = {{(DATA_W-MEM_AW){1'b0}}, opnd};
          OP_JMP: pc_nx = opnd;
          OP_JC:  if (c_flag) pc_nx = opnd;
          OP_JZ:  if (z_flag) pc_nx = opnd;
`ifdef MC_EXT_ALU_EN
          OP_AND: begin acc_nx = acc & opnd_data; c_nx = 1'b0; z_nx = (acc_nx == '0); end
          OP_OR:  begin acc_nx = acc | opnd_data; c_nx = 1'b0; z_nx = (acc_nx == '0); end
          OP_XOR: begin acc_nx = acc ^ opnd_data; c_nx = 1'b0; z_nx = (acc_nx == '0); end
          OP_SHL: begin {c_nx, acc_nx} = {acc, 1'b0}; z_nx = (acc_nx == '0); end
          OP_SHR: begin {acc_nx, c_nx} = {1'b0, acc}; z_nx = (acc_nx == '0); end
`endif
          OP_OUT: begin
            out_nx       = acc;
            out_valid_nx = 1'b1;
          end
          OP_HLT: begin
            state_nx  = S_HALT;
            halted_nx = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT:  ;
      default: state_nx = S_FETCH;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= '0;
      acc       <= '0;
      ir        <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      acc       <= acc_nx;
      ir        <= ir_nx;
      c_flag    <= c_nx;
      z_flag    <= z_nx;
      out_data  <= out_nx;
      out_valid <= out_valid_nx;
      halted    <= halted_nx;
    end
  end

  // NOTE: the RAM is deliberately left out of reset; a reset must not wipe a preloaded program.
  // A CPU store wins over a host write that lands on the same edge.
  always_ff @(posedge clk) begin
    if (cpu_we)
      mem[opnd] <= acc;
    else if (prog_we && !run)
      mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_micro_computer.sv
// Self-checking bench for micro_computer: directed programs plus random programs, checked against
// an instruction-level model; OUT results go through a scoreboard queue popped by a monitor.
module tb_micro_computer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc;
  logic [7:0] acc;

  micro_computer #(.DATA_W(8), .MEM_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out_data(out_data), .out_valid(out_valid), .halted(halted),
    .pc(pc), .acc(acc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instruction-level reference model
  int m_mem [16];
  int m_pc, m_acc, m_c, m_z, m_halted, m_out;
  int exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_halted = 0; m_out = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int ir, op, a, d;
    ir = m_mem[m_pc];
    m_pc = (m_pc + 1) % 16;
    op = ir / 16;
    a  = ir % 16;
    d  = m_mem[a];
    case (op)
      1:  m_acc = d;
      2:  begin m_c = (m_acc + d > 255); m_acc = (m_acc + d) % 256; m_z = (m_acc == 0); end
      3:  begin m_c = (m_acc < d); m_acc = (m_acc - d + 256) % 256; m_z = (m_acc == 0); end
      4:  m_mem[a] = m_acc;
      5:  m_acc = a;
      6:  m_pc = a;
      7:  if (m_c != 0) m_pc = a;
      8:  if (m_z != 0) m_pc = a;
`ifdef MC_EXT_ALU_EN
      9:  begin m_acc = m_acc & d; m_c = 0; m_z = (m_acc == 0); end
      10: begin m_acc = m_acc | d; m_c = 0; m_z = (m_acc == 0); end
      11: begin m_acc = m_acc ^ d; m_c = 0; m_z = (m_acc == 0); end
      12: begin m_c = m_acc / 128; m_acc = (m_acc * 2) % 256; m_z = (m_acc == 0); end
      13: begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
`endif
      14: begin m_out = m_acc; exp_q.push_back(m_acc); end
      15: m_halted = 1;
      default: ;
    endcase
  endtask

  // Monitor: every out_valid cycle pops one expected OUT value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected no output", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    run = 1'b0;
    prog_we = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic load_prog(input logic [7:0] p [16]);
    for (int i = 0; i < 16; i++) load(4'(i), p[i]);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_acc"}, acc, m_acc);
    check({tag, "_halted"}, halted, m_halted);
    check({tag, "_out_data"}, out_data, m_out);
  endtask

  // Run n clocks with run=1 (optionally with a host write held on the load port), then drop run
  // and give any instruction in flight time to finish.
  task automatic run_cycles(input string tag, input int n, input bit junk,
                            input logic [3:0] ja, input logic [7:0] jd);
    int halt_at = -1;
    int first = -1;
    int k = (n + 1) / 2;
    for (int i = 0; i < k; i++) begin
      if (m_halted != 0) break;
      model_step();
      if (m_halted != 0) halt_at = 2 * (i + 1);
    end
    if (junk) begin
      prog_addr = ja;
      prog_data = jd;
      prog_we = 1'b1;
    end
    run = 1'b1;
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      @(posedge clk); #1;
      if (cyc == n) begin
        run = 1'b0;
        prog_we = 1'b0;
      end
      if (halted === 1'b1 && first < 0) first = cyc;
    end
    @(negedge clk); #1;
    if (halt_at >= 0) check({tag, "_halt_cycle"}, first, halt_at);
    check({tag, "_pending_outs"}, exp_q.size(), 0);
    exp_q.delete();
    check_state(tag);
  endtask

  logic [7:0] p [16];

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    model_reset();
    do_reset();
    check("reset_pc", pc, 4'h0);
    check("reset_acc", acc, 8'h00);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_halted", halted, 1'b0);

    // LDA E; ADD F; OUT; HLT -> 05+03
    p = '{8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h03};
    load_prog(p);
    run_cycles("add", 12, 1'b0, 4'h0, 8'h00);
    check("add_result", out_data, 8'h08);

    // Asynchronous reset in the middle of a clock period, no edge needed
    run = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 4'h0);
    check("async_acc", acc, 8'h00);
    check("async_out_data", out_data, 8'h00);
    check("async_halted", halted, 1'b0);
    do_reset();

    // LDI 5; SUB F; JC 4; HLT; OUT; HLT, with run dropped mid-instruction first
    p = '{8'h55, 8'h3F, 8'h74, 8'hF0, 8'hE0, 8'hF0, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06};
    load_prog(p);
    run_cycles("borrow_part", 5, 1'b0, 4'h0, 8'h00);
    check("borrow_acc", acc, 8'hFF);
    run_cycles("borrow", 10, 1'b0, 4'h0, 8'h00);
    check("borrow_out", out_data, 8'hFF);

    // Countdown loop: LDA D; SUB E; JZ 4; JMP 1; HLT -> 10 instructions
    do_reset();
    p = '{8'h1D, 8'h3E, 8'h84, 8'h61, 8'hF0, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h00};
    load_prog(p);
    run_cycles("countdown", 30, 1'b0, 4'h0, 8'h00);
    check("countdown_pc", pc, 4'h5);

    // Host writes: ignored while running, honoured while idle
    do_reset();
    p = '{8'h1A, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_prog(p);
    run_cycles("we_run", 4, 1'b1, 4'hA, 8'h99);
    check("we_run_out", out_data, 8'h11);
    load(4'hA, 8'h22);
    load(4'h2, 8'h1A);
    load(4'h3, 8'hE0);
    load(4'h4, 8'hF0);
    check_state("we_idle");
    run_cycles("we_idle_run", 6, 1'b0, 4'h0, 8'h00);
    check("we_idle_out", out_data, 8'h22);

    // SHL of 81 (NOP when the ALU extension is absent), then JC observes C
    do_reset();
    p = '{8'h1A, 8'hC0, 8'hE0, 8'h75, 8'hF0, 8'hE0, 8'hF0, 8'h00,
          8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_prog(p);
    run_cycles("shl", 20, 1'b0, 4'h0, 8'h00);

    // Random programs, each run in two segments without reset in between
    for (int t = 0; t < 25; t++) begin
      do_reset();
      for (int i = 0; i < 16; i++) p[i] = 8'($urandom);
      load_prog(p);
      run_cycles("rand_a", int'($urandom_range(1, 50)), 1'b0, 4'h0, 8'h00);
      run_cycles("rand_b", int'($urandom_range(1, 20)), 1'b0, 4'h0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
